// File: rtl/adc_decimator_pkg.sv
// adc_decimator_pkg: shared widths, FIFO depth bounds and the conf_decim clamp
package adc_decimator_pkg;
  localparam int ADC_W = 8;
  localparam int MAX_LOG2_DEF = 4;
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 16;
  function automatic logic [2:0] clamp_k(input logic [2:0] conf, input int max_log2);
    return (int'(conf) > max_log2) ? 3'(max_log2) : conf;
  endfunction
endpackage

// File: rtl/adc_decimator_sample_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO; head reads 0 when empty
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    full_o = cnt_q == (PW+1)'(DEPTH);
    empty_o = cnt_q == '0;
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    data_o = empty_o ? '0 : mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_q + PW'(do_pop);
      wr_q <= wr_q + PW'(do_push);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
endmodule

// File: rtl/adc_decimator.sv
// adc_decimator: power-of-two window averaging of ADC samples into a FIFO,
// with a hysteresis comparator on every window mean and a sticky drop flag.
module adc_decimator
  import adc_decimator_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic             pck0,
  input  logic             rst,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             adc_en,
  input  logic [2:0]       conf_decim,
  input  logic [ADC_W-1:0] thresh_hi,
  input  logic [ADC_W-1:0] thresh_lo,
  output logic [ADC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             edge_bit,
  output logic             overflow
);
  localparam int AW = ADC_W + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] k_q, k_d, kk;
  logic open_q, open_d, push_q, push_d, edge_q, edge_d, ovf_q, ovf_d, last;
  logic [ADC_W-1:0] mean_q, mean_d;
  logic full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  always_comb begin
    kk = open_q ? k_q : clamp_k(conf_decim, MAX_LOG2);
    sum = acc_q + AW'(adc_d);
    last = cnt_q == CW'((32'd1 << kk) - 32'd1);
    push_d = adc_en && last;
    mean_d = push_d ? ADC_W'(sum >> kk) : mean_q;
    acc_d = adc_en ? (last ? '0 : sum) : acc_q;
    cnt_d = adc_en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    open_d = adc_en ? !last : open_q;
    k_d = adc_en ? kk : k_q;
    // set wins over clear when the thresholds overlap
    edge_d = !push_q ? edge_q : (mean_q >= thresh_hi) ? 1'b1 : (mean_q <= thresh_lo) ? 1'b0 : edge_q;
    ovf_d = ovf_q | (push_q & full & ~out_ready);
  end
  always_ff @(posedge pck0)
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      open_q <= 1'b0;
      push_q <= 1'b0;
      mean_q <= '0;
      edge_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      open_q <= open_d;
      push_q <= push_d;
      mean_q <= mean_d;
      edge_q <= edge_d;
      ovf_q <= ovf_d;
    end
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(ADC_W)) u_fifo (
    .clk(pck0),
    .rst(rst),
    .push_i(push_q),
    .pop_i(out_ready),
    .data_i(mean_q),
    .data_o(out_data),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  assign out_valid = !empty;
  assign edge_bit = edge_q;
  assign overflow = ovf_q;
endmodule
